mbox_ebox_resp: RTL

MBOX_EBOX_RESP -- requirements
Module: mbox_ebox_resp

---
 rtl/mbox_ebox_resp.sv | 121 ++++++++++++
 1 files changed

// File: rtl/mbox_ebox_resp.sv
// EBOX-side memory cycle responder: accepts EBOX requests, runs one backing-store
// transaction each, and reports read data, completion, page-fail or NXM abort.
module mbox_ebox_resp #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        RESET,
    input  logic        MBOX_CYC_REQ,
    input  logic [22:0] VMA,
    input  logic        LOAD_AR,
    input  logic        LOAD_ARX,
    input  logic        VMA_FETCH,
    input  logic        VMA_WRITE,
    input  logic        VMA_PAUSE,
    input  logic        VMA_ADR_ERR,
    input  logic [35:0] AR,
    output logic        MB_WAIT,
    output logic        MBOX_XFER,
    output logic        MBOX_RESP,
    output logic [35:0] MEM_DATA,
    output logic        PAGE_FAIL,
    output logic        NXM_ERR,
    output logic        MEM_REQ,
    output logic        MEM_WE,
    output logic [22:0] MEM_ADDR,
    output logic [35:0] MEM_WDATA,
    input  logic        MEM_ACK,
    input  logic [35:0] MEM_RDATA
);
    localparam int CW = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, RD, WR, PAUSE, ERR} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          rpw_q;
    logic          is_read;
    logic          pause_wr;

    assign is_read  = LOAD_AR | LOAD_ARX | VMA_FETCH;
    assign pause_wr = (state == PAUSE) & VMA_WRITE;

    always_ff @(posedge clk) begin
        if (RESET) begin
            state     <= IDLE;
            cnt       <= '0;
            rpw_q     <= 1'b0;
            MB_WAIT   <= 1'b0;
            MBOX_XFER <= 1'b0;
            MBOX_RESP <= 1'b0;
            PAGE_FAIL <= 1'b0;
            NXM_ERR   <= 1'b0;
            MEM_DATA  <= '0;
            MEM_REQ   <= 1'b0;
            MEM_WE    <= 1'b0;
            MEM_ADDR  <= '0;
            MEM_WDATA <= '0;
        end else begin
            MBOX_XFER <= 1'b0;
            MBOX_RESP <= 1'b0;
            PAGE_FAIL <= 1'b0;
            NXM_ERR   <= 1'b0;
            case (state)
                IDLE, PAUSE: begin
                    if (MBOX_CYC_REQ) begin
                        MEM_WDATA <= AR;
                        cnt       <= '0;
                        // The write half of a read-pause-write reuses the read address.
                        if (!pause_wr) MEM_ADDR <= VMA;
                        if (VMA_ADR_ERR) begin
                            state     <= ERR;
                            MB_WAIT   <= 1'b1;
                            PAGE_FAIL <= 1'b1;
                        end else if (pause_wr || (VMA_WRITE && !is_read)) begin
                            state   <= WR;
                            MB_WAIT <= 1'b1;
                            MEM_REQ <= 1'b1;
                            MEM_WE  <= 1'b1;
                        end else if (is_read) begin
                            state   <= RD;
                            MB_WAIT <= 1'b1;
                            MEM_REQ <= 1'b1;
                            MEM_WE  <= 1'b0;
                            rpw_q   <= VMA_PAUSE;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                RD, WR: begin
                    if (MEM_ACK) begin
                        MEM_REQ   <= 1'b0;
                        MEM_WE    <= 1'b0;
                        MB_WAIT   <= 1'b0;
                        MBOX_RESP <= 1'b1;
                        if (state == RD) begin
                            MEM_DATA  <= MEM_RDATA;
                            MBOX_XFER <= 1'b1;
                            state     <= rpw_q ? PAUSE : IDLE;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (cnt == CW'(MEM_TIMEOUT - 1)) begin
                        // Count reaches the limit on this edge: abort as non-existent memory.
                        MEM_REQ <= 1'b0;
                        MEM_WE  <= 1'b0;
                        MB_WAIT <= 1'b0;
                        NXM_ERR <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    MB_WAIT <= 1'b0;
                end
            endcase
        end
    end
endmodule
